sotasoc_uart_io_hub: RTL and testbench
======================================

# sotasoc_uart_io_hub

Tiny Tapeout top-level SoC block that exposes its I/O pins as a small register file controlled by a host over an 8N1 UART. Commands arrive on `ui_in[0]`, and responses leave on `uo_out[0]`. The remaining dedicated pins and all bidirectional pins act as GPIO, and a 16-bit free-running timer is built in. It sits directly under the Tiny Tapeout harness as the user project.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit (≥4, even).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-high reset. The pin name follows the harness convention; logic 1 resets.
- `ena` in 1: ignored.
- `ui_in` in 8: [0] UART RX; [7:1] GPIO inputs.
- `uo_out` out 8: [0] UART TX, idle high; [7:1] = GPIO_OUT[6:0].
- `uio_in` in 8: bidirectional pin input values.
- `uio_out` out 8: = UIO_OUT register.
- `uio_oe` out 8: = UIO_OE register (1 = output).

## Operation
- **RX path**
  - `ui_in[0]` passes through a 2-flop synchronizer.
  - A high→low transition while the receiver is idle starts a frame.
  - The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the frame is aborted.
  - Data bits are sampled LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - The stop bit must read 1, otherwise the byte is discarded and the command FSM is unchanged.
- **Command FSM**
  - States: IDLE and WAIT_DATA.
  - IDLE, byte with bit7=0: read of address b[2:0]. The response byte is the register value; stay in IDLE.
  - IDLE, byte with bit7=1: latch address b[2:0] and go to WAIT_DATA.
  - WAIT_DATA, next byte: write that byte to the latched address, send ACK 0xA5, return to IDLE.
  - Bits [6:3] of the command are ignored.
- **Registers**
  - 0 GPIO_OUT, R/W: bit7 reads 0.
  - 1 UIO_OUT, R/W.
  - 2 UIO_OE, R/W.
  - 3 GPIO_IN, RO: {synced `ui_in[7:1]`, 0}.
  - 4 UIO_IN, RO: synced `uio_in`.
  - 5 TMR_LO: a read returns counter[7:0] and latches counter[15:8] into a shadow; a write clears the counter to 0.
  - 6 TMR_HI, RO: returns the shadow.
  - 7 SCRATCH, R/W.
  - Writes to read-only registers are ignored but still ACKed.
- **TX path**
  - 8N1, LSB first, each bit held CLKS_PER_BIT cycles.
  - One pending-byte buffer. If a response is due while TX is busy, it goes to the buffer. If the buffer is full, the new response is dropped.
- **Timer**: 16-bit counter incrementing every cycle and wrapping 0xFFFF→0x0000.

## Timing
- **Reset values**
  - `uo_out` = 0x01.
  - `uio_out` = 0x00, `uio_oe` = 0x00.
  - All registers, timer and shadow = 0.
  - FSM in IDLE, TX idle, pending buffer empty.
- **Write latency**: the register and its pin update on the clock edge following the data byte's stop-bit sample.
- **Response latency**: the TX start bit (`uo_out[0]`=0) begins 2 cycles after the stop-bit sample, when TX is idle.
- **Read snapshot**: a read returns the register value at the stop-bit sample edge.
- **Reset mid-frame**: reset aborts RX, TX and the FSM immediately. TX returns high on the next cycle.
- **Simultaneous events**: a TMR_LO clear and the counter increment in the same cycle give 0.

## Configuration
- `SOTASOC_TIMER_EN` defined: timer and shadow are present as above.
- Undefined: no counter logic. Registers 5 and 6 read 0x00, and writes to them are ACKed and ignored.

## Structure
- Package `sotasoc_pkg` holds:
  - register address localparams (0–7);
  - `ACK_BYTE` = 8'hA5;
  - command write-bit index (7);
  - FSM state enum.
- Sub-module `sotasoc_uart_rx` contains the synchronizer, bit timer and shift register. It outputs `rx_data[7:0]` and a one-cycle `rx_valid`.
- TX, FSM, registers and timer stay in the top.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Reset, then idle 100 cycles → `uo_out`=0x01, `uio_oe`=0x00, no TX activity.
- Send 0x80, 0x54 → ACK 0xA5 returned; `uo_out`=0xA9. Then send 0x00 → response 0x54.
- Send 0x82, 0xF0, then 0x81, 0x5A → `uio_oe`=0xF0, `uio_out`=0x5A. With `uio_in`=0x3C, send 0x04 → response 0x3C.
- Send a frame with stop bit 0 carrying 0x81, then a good 0x07 → no ACK; response 0x00 (SCRATCH). A write was not armed.
- Send 0x85, 0x00 (clear timer), then 0x05, then 0x06 → high byte consistent with the latched value; both equal 0 when `SOTASOC_TIMER_EN` is undefined.
- Send 0x87 and pulse reset before the data byte → FSM in IDLE; a following byte 0x07 is treated as a read returning 0x00.

Source files
------------

// File: rtl/sotasoc_pkg.sv
// rtl/sotasoc_pkg.sv - shared register map, ack byte, command layout and FSM state type
package sotasoc_pkg;

  localparam logic [2:0] ADDR_GPIO_OUT = 3'd0;
  localparam logic [2:0] ADDR_UIO_OUT  = 3'd1;
  localparam logic [2:0] ADDR_UIO_OE   = 3'd2;
  localparam logic [2:0] ADDR_GPIO_IN  = 3'd3;
  localparam logic [2:0] ADDR_UIO_IN   = 3'd4;
  localparam logic [2:0] ADDR_TMR_LO   = 3'd5;
  localparam logic [2:0] ADDR_TMR_HI   = 3'd6;
  localparam logic [2:0] ADDR_SCRATCH  = 3'd7;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_DATA
  } cmd_state_t;

endpackage

// File: rtl/sotasoc_uart_rx.sv
// rtl/sotasoc_uart_rx.sv - 8N1 receiver with input synchronizer, emits one-cycle rx_valid per good byte
module sotasoc_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      state;
  logic           sync_meta, sync_rx, sync_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      sync_meta <= rx;
      sync_rx   <= sync_meta;
      sync_prev <= sync_rx;
      rx_valid  <= 1'b0;
      case (state)
        RX_IDLE: if (sync_prev && !sync_rx) begin
          state <= RX_START;
          cnt   <= '0;
        end
        // A start bit that is high again at mid-bit was a glitch.
        RX_START: if (cnt == HALF_LAST) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= sync_rx ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == BIT_LAST) begin
          cnt   <= '0;
          shreg <= {sync_rx, shreg[7:1]};
          if (bit_idx == 3'd7) state <= RX_STOP;
          else bit_idx <= bit_idx + 1'b1;
        end else cnt <= cnt + 1'b1;
        RX_STOP: if (cnt == BIT_LAST) begin
          state <= RX_IDLE;
          if (sync_rx) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sotasoc_uart_io_hub.sv
// rtl/sotasoc_uart_io_hub.sv - UART-controlled GPIO register hub; SOTASOC_TIMER_EN adds the 16-bit timer
module sotasoc_uart_io_hub
  import sotasoc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [6:0]    gpi_meta, gpi_sync;
  logic [7:0]    uioi_meta, uioi_sync;
  logic [6:0]    gpio_out;
  logic [7:0]    uio_out_r, uio_oe_r, scratch;
  logic [7:0]    tmr_lo, tmr_hi, rd_data;
  cmd_state_t    state;
  logic [2:0]    wr_addr;
  logic          resp_valid;
  logic [7:0]    resp_data;
  logic          tx_busy, tx_out;
  logic [8:0]    tx_sr;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic          buf_valid;
  logic [7:0]    buf_data;
  logic          buf_pop, buf_push, resp_direct, tx_start;
  logic [7:0]    tx_start_byte;
  logic          unused_ena;

  assign unused_ena = ena;

  sotasoc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst_n),
    .rx       (ui_in[0]),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      gpi_meta  <= '0;
      gpi_sync  <= '0;
      uioi_meta <= '0;
      uioi_sync <= '0;
    end else begin
      gpi_meta  <= ui_in[7:1];
      gpi_sync  <= gpi_meta;
      uioi_meta <= uio_in;
      uioi_sync <= uioi_meta;
    end
  end

`ifdef SOTASOC_TIMER_EN
  logic [15:0] timer;
  logic [7:0]  shadow;
  logic        tmr_rd, tmr_clr;

  assign tmr_rd  = rx_valid && (state == ST_IDLE) && !rx_data[CMD_WRITE_BIT] && (rx_data[2:0] == ADDR_TMR_LO);
  assign tmr_clr = rx_valid && (state == ST_WAIT_DATA) && (wr_addr == ADDR_TMR_LO);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      timer  <= '0;
      shadow <= '0;
    end else begin
      timer <= tmr_clr ? 16'h0000 : timer + 16'h0001;
      if (tmr_rd) shadow <= timer[15:8];
    end
  end

  assign tmr_lo = timer[7:0];
  assign tmr_hi = shadow;
`else
  assign tmr_lo = 8'h00;
  assign tmr_hi = 8'h00;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (rx_data[2:0])
      ADDR_GPIO_OUT: rd_data = {1'b0, gpio_out};
      ADDR_UIO_OUT:  rd_data = uio_out_r;
      ADDR_UIO_OE:   rd_data = uio_oe_r;
      ADDR_GPIO_IN:  rd_data = {gpi_sync, 1'b0};
      ADDR_UIO_IN:   rd_data = uioi_sync;
      ADDR_TMR_LO:   rd_data = tmr_lo;
      ADDR_TMR_HI:   rd_data = tmr_hi;
      ADDR_SCRATCH:  rd_data = scratch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      wr_addr    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      gpio_out   <= '0;
      uio_out_r  <= '0;
      uio_oe_r   <= '0;
      scratch    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_IDLE: if (rx_data[CMD_WRITE_BIT]) begin
            wr_addr <= rx_data[2:0];
            state   <= ST_WAIT_DATA;
          end else begin
            resp_data  <= rd_data;
            resp_valid <= 1'b1;
          end
          ST_WAIT_DATA: begin
            case (wr_addr)
              ADDR_GPIO_OUT: gpio_out  <= rx_data[6:0];
              ADDR_UIO_OUT:  uio_out_r <= rx_data;
              ADDR_UIO_OE:   uio_oe_r  <= rx_data;
              ADDR_SCRATCH:  scratch   <= rx_data;
              default: ;
            endcase
            resp_data  <= ACK_BYTE;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // A response goes straight to the line only when nothing is queued ahead of it.
  always_comb begin
    buf_pop       = !tx_busy && buf_valid;
    resp_direct   = resp_valid && !tx_busy && !buf_valid;
    buf_push      = resp_valid && !resp_direct && (!buf_valid || buf_pop);
    tx_start      = buf_pop || resp_direct;
    tx_start_byte = buf_pop ? buf_data : resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_busy   <= 1'b0;
      tx_out    <= 1'b1;
      tx_sr     <= '1;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else begin
      if (buf_push) begin
        buf_valid <= 1'b1;
        buf_data  <= resp_data;
      end else if (buf_pop) buf_valid <= 1'b0;
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_out  <= 1'b0;
        tx_sr   <= {1'b1, tx_start_byte};
        tx_bit  <= '0;
        tx_cnt  <= '0;
      end else if (tx_busy) begin
        if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
          else begin
            tx_out <= tx_sr[0];
            tx_sr  <= {1'b1, tx_sr[8:1]};
            tx_bit <= tx_bit + 1'b1;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign uo_out  = {gpio_out, tx_out};
  assign uio_out = uio_out_r;
  assign uio_oe  = uio_oe_r;

endmodule

// File: tb/tb_sotasoc_uart_io_hub.sv
// tb/tb_sotasoc_uart_io_hub.sv - directed vector bench for the UART I/O hub (timer checks follow SOTASOC_TIMER_EN)
module tb_sotasoc_uart_io_hub;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] mon_b;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    logic [7:0] cmd;
    logic       is_wr;
    logic [7:0] data;
    logic [7:0] pins_in;
    logic [7:0] resp;
    logic [7:0] uo;
    logic [7:0] uo_uio;
    logic [7:0] oe;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;
  assign ui_in = {7'h55, rx_line};

  sotasoc_uart_io_hub #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Host-side receiver: samples mid-bit on the falling edge.
  always begin
    @(negedge clk);
    if (!rst && uo_out[0] == 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = uo_out[0];
      end
      repeat (CPB) @(negedge clk);
      tests++;
      if (uo_out[0] !== 1'b1) begin
        fails++;
        $display("FAIL tx_stop_bit: got %b, required 1", uo_out[0]);
      end
      rx_q.push_back(mon_b);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, required %02h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len, input int gap);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop;
    repeat (stop_len) @(negedge clk);
    rx_line = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, CPB, 4);
  endtask

  task automatic get_resp(output logic [7:0] b, output bit ok);
    int n = 0;
    while (rx_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (rx_q.size() != 0);
    b  = 8'h00;
    if (ok) b = rx_q.pop_front();
  endtask

  task automatic expect_resp(input string name, input logic [7:0] exp);
    logic [7:0] b;
    bit ok;
    get_resp(b, ok);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: got no response within 400 cycles, required %02h", name, exp);
    end else check8(name, b, exp);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    repeat (cycles) @(negedge clk);
    check8(name, 8'(rx_q.size()), 8'd0);
  endtask

  initial begin
    logic [7:0] lo, hi;
    bit ok;
    int act;

    vecs[0]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    vecs[1]  = '{8'h80, 1'b1, 8'h54, 8'h00, 8'hA5, 8'hA9, 8'h00, 8'h00};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h54, 8'hA9, 8'h00, 8'h00};
    vecs[3]  = '{8'h80, 1'b1, 8'hFF, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'h00};
    vecs[4]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h00};
    vecs[5]  = '{8'h82, 1'b1, 8'hF0, 8'h00, 8'hA5, 8'hFF, 8'h00, 8'hF0};
    vecs[6]  = '{8'h81, 1'b1, 8'h5A, 8'h00, 8'hA5, 8'hFF, 8'h5A, 8'hF0};
    vecs[7]  = '{8'h04, 1'b0, 8'h00, 8'h3C, 8'h3C, 8'hFF, 8'h5A, 8'hF0};
    vecs[8]  = '{8'h02, 1'b0, 8'h00, 8'h3C, 8'hF0, 8'hFF, 8'h5A, 8'hF0};
    vecs[9]  = '{8'h01, 1'b0, 8'h00, 8'h3C, 8'h5A, 8'hFF, 8'h5A, 8'hF0};
    vecs[10] = '{8'h87, 1'b1, 8'hC3, 8'h3C, 8'hA5, 8'hFF, 8'h5A, 8'hF0};
    vecs[11] = '{8'h7F, 1'b0, 8'h00, 8'h3C, 8'hC3, 8'hFF, 8'h5A, 8'hF0};
    vecs[12] = '{8'h83, 1'b1, 8'h12, 8'h3C, 8'hA5, 8'hFF, 8'h5A, 8'hF0};
    vecs[13] = '{8'h03, 1'b0, 8'h00, 8'h3C, 8'hAA, 8'hFF, 8'h5A, 8'hF0};
    vecs[14] = '{8'h84, 1'b1, 8'h99, 8'hA6, 8'hA5, 8'hFF, 8'h5A, 8'hF0};
    vecs[15] = '{8'h04, 1'b0, 8'h00, 8'hA6, 8'hA6, 8'hFF, 8'h5A, 8'hF0};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b1) act++;
    end
    check8("reset_uo_out", uo_out, 8'h01);
    check8("reset_uio_oe", uio_oe, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("idle_tx_activity", 8'(act + rx_q.size()), 8'd0);

    send_frame(8'h81, 1'b0, CPB, 4);
    expect_quiet("bad_stop_no_ack", 200);
    send_byte(8'h07);
    expect_resp("bad_stop_then_read", 8'h00);
    expect_quiet("bad_stop_single_resp", 200);

    send_byte(8'h87);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'h07);
    expect_resp("reset_mid_cmd_read", 8'h00);

    for (int i = 0; i < 16; i++) begin
      uio_in = vecs[i].pins_in;
      send_byte(vecs[i].cmd);
      if (vecs[i].is_wr) send_byte(vecs[i].data);
      expect_resp($sformatf("vec%0d_resp", i), vecs[i].resp);
      check8($sformatf("vec%0d_uo_out", i), uo_out, vecs[i].uo);
      check8($sformatf("vec%0d_uio_out", i), uio_out, vecs[i].uo_uio);
      check8($sformatf("vec%0d_uio_oe", i), uio_oe, vecs[i].oe);
    end

    // Short stop bits make responses arrive faster than TX drains them.
    send_frame(8'h07, 1'b1, 13, 0);
    send_frame(8'h00, 1'b1, 13, 0);
    send_frame(8'h02, 1'b1, 13, 4);
    expect_resp("pending_first", 8'hC3);
    expect_resp("pending_second", 8'h7F);
    expect_resp("pending_third", 8'hF0);
    expect_quiet("pending_no_extra", 200);

    send_byte(8'h07);
    act = 0;
    while (uo_out[0] !== 1'b0 && act < 100) begin
      @(negedge clk);
      act++;
    end
    check8("tx_start_seen", {7'b0, uo_out[0]}, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("reset_tx_high", uo_out, 8'h01);
    check8("reset_clears_oe", uio_oe, 8'h00);
    check8("reset_clears_uio", uio_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    rx_q.delete();

    send_byte(8'h85);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h06);
    expect_resp("tmr_clear_ack", 8'hA5);
    get_resp(lo, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL tmr_lo_resp: got no response, required a timer byte");
    end
    get_resp(hi, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL tmr_hi_resp: got no response, required a shadow byte");
    end
`ifdef SOTASOC_TIMER_EN
    tests++;
    if (lo < 8'd100 || lo > 8'd250) begin
      fails++;
      $display("FAIL tmr_lo_range: got %02h, required 64..FA", lo);
    end
    check8("tmr_hi_shadow", hi, 8'h00);
`else
    check8("tmr_lo_absent", lo, 8'h00);
    check8("tmr_hi_absent", hi, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
